reg_file_ctx: RTL and testbench
===============================

// Module: reg_file_ctx
// PURPOSE
//  Parametrised successor to the core register file: 2**D x W regs, two async read ports,
//  one write port and an in-file register-to-register move.
//  Adds a context engine: spill streams all regs out (valid/ready), fill streams them back in.
//  Sits between decode/ALU and data memory; spill/fill are used for call/interrupt context switch.
// PARAMETERS
//  W    8  data path width
//  D    4  register pointer width; NREG = 2**D
// PORTS
//  Clk        in   1  clock, all state on posedge
//  Reset      in   1  asynchronous, active-high; clears all state
//  RaddrA     in   D  read pointer A
//  RaddrB     in   D  read pointer B
//  DataOutA   out  W  Registers[RaddrA], combinational
//  DataOutB   out  W  Registers[RaddrB], combinational
//  WriteEn    in   1  write DataIn to Registers[Waddr]
//  Waddr      in   D  write pointer
//  DataIn     in   W  write data
//  MoveEn     in   1  Registers[MoveDst] <= Registers[MoveSrc]
//  MoveSrc    in   D  move source
//  MoveDst    in   D  move destination
//  R0Zero     out  1  Registers[0]==0
//  R1Val      out  W  Registers[1]
//  SpillReq   in   1  start spill (sampled in IDLE only)
//  FillReq    in   1  start fill (sampled in IDLE only)
//  Busy       out  1  engine in SPILL or FILL
//  CtxDone    out  1  one-cycle pulse after last beat
//  SpValid    out  1  spill beat valid
//  SpReady    in   1  spill beat accepted
//  SpAddr     out  D  register index of spill beat
//  SpData     out  W  Registers[SpAddr]
//  FlValid    in   1  fill beat valid
//  FlReady    out  1  fill beat accepted
//  FlData     in   W  fill data, written to Registers[beat count]
// BEHAVIOUR
//  Reset: all regs 0, state IDLE, cnt 0; Busy/CtxDone/SpValid/FlReady 0, R0Zero 1, R1Val 0.
//  IDLE: WriteEn and MoveEn commit at posedge. Same dst: WriteEn wins.
//   Move reads the pre-edge value (swap-safe).
//  SpillReq&FillReq same cycle: spill wins, fill dropped.
//   Write in the request cycle commits first, so spill sees it.
//  SPILL: SpValid=1, SpAddr=cnt, SpData=Registers[cnt]; cnt++ on SpValid&SpReady.
//   Beat NREG-1 handshake -> DONE. SpReady low holds addr/data stable.
//  FILL: FlReady=1; on FlValid&FlReady, Registers[cnt]<=FlData, cnt++.
//   Beat NREG-1 -> DONE.
//  DONE: CtxDone=1 for one cycle, cnt<=0, -> IDLE.
//  Busy=1 in SPILL/FILL; WriteEn, MoveEn and new requests are ignored (caller stalls).
//  Read ports stay live while Busy.
//  cnt is D bits, no wrap beyond NREG-1; exactly NREG beats per op.
//  Reset mid-op: immediate IDLE, partial fill discarded (regs cleared), no CtxDone.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: in IDLE with WriteEn=1, a read port whose addr==Waddr
//   returns DataIn the same cycle. R0Zero/R1Val also reflect pending write.
//  Not defined: reads return the stored value; the new value is visible the cycle after the edge.
// STRUCTURE
//  definitions package: typedef enum logic[1:0] {CTX_IDLE,CTX_SPILL,CTX_FILL,CTX_DONE} ctx_state_t.
//  Sub-module regfile_ctx_fsm owns state, cnt, Busy/CtxDone/SpValid/FlReady.
//   It outputs cnt and fill-write strobe; the array and read/write muxing stay in reg_file_ctx.
// TESTING (W=8,D=4)
//  Write R3=0x5A, R7=0xA5; read A=3,B=7 next cycle -> 0x5A,0xA5; R0Zero=1.
//  R2=0x11,R4=0x22; same cycle WriteEn R4=0x99 + Move R4<-R2 -> R4=0x99; then move R2->R4 -> R4=0x11.
//  Load R0..R15=i*3; SpillReq, SpReady toggles 1,0,1... -> 16 beats addr 0..15 data i*3, addr held while not ready, CtxDone 1 cycle.
//  FillReq with FlData=0xF0+i, FlValid gaps -> Registers[i]=0xF0+i; R0Zero=0; WriteEn during Busy ignored.
//  SpillReq+FillReq same cycle -> SPILL only; Reset asserted at beat 6 of fill -> Busy 0, all regs 0, no CtxDone.
//  REGFILE_BYPASS_EN: WriteEn R5=0x3C, RaddrA=5 same cycle -> DataOutA=0x3C (without macro: old value).

Source files
------------

// File: rtl/reg_file_ctx_pkg.sv
// Shared definitions for the register file with context spill/fill engine.
package reg_file_ctx_pkg;

  typedef enum logic [1:0] {CTX_IDLE, CTX_SPILL, CTX_FILL, CTX_DONE} ctx_state_t;

  localparam int W_DEF = 8;
  localparam int D_DEF = 4;

  // Number of registers addressed by a d-bit pointer.
  function automatic int nreg(input int d);
    return 1 << d;
  endfunction

endpackage

// File: rtl/reg_file_ctx_fsm.sv
// Context engine sequencer: owns state, beat counter and handshake outputs.
// The register array itself lives in reg_file_ctx.
module regfile_ctx_fsm
  import reg_file_ctx_pkg::*;
#(
  parameter int D = D_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spill_req,
  input  logic         fill_req,
  input  logic         sp_ready,
  input  logic         fl_valid,
  output logic         busy,
  output logic         ctx_done,
  output logic         sp_valid,
  output logic         fl_ready,
  output logic         fill_we,
  output logic [D-1:0] cnt
);

  localparam logic [D-1:0] LAST = {D{1'b1}};

  ctx_state_t state;

  // Fill beat writes Registers[cnt] at the coming edge.
  assign fill_we = (state == CTX_FILL) && fl_valid;

  // Sequencer with registered handshake outputs; spill has priority over fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CTX_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      ctx_done <= 1'b0;
      sp_valid <= 1'b0;
      fl_ready <= 1'b0;
    end else begin
      case (state)
        CTX_IDLE: begin
          if (spill_req) begin
            state    <= CTX_SPILL;
            busy     <= 1'b1;
            sp_valid <= 1'b1;
          end else if (fill_req) begin
            state    <= CTX_FILL;
            busy     <= 1'b1;
            fl_ready <= 1'b1;
          end
        end
        CTX_SPILL: begin
          if (sp_ready) begin
            if (cnt == LAST) begin
              state    <= CTX_DONE;
              busy     <= 1'b0;
              sp_valid <= 1'b0;
              ctx_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CTX_FILL: begin
          if (fl_valid) begin
            if (cnt == LAST) begin
              state    <= CTX_DONE;
              busy     <= 1'b0;
              fl_ready <= 1'b0;
              ctx_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= CTX_IDLE;
          cnt      <= '0;
          ctx_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_file_ctx.sv
// 2**D x W register file with two async read ports, one write port, an
// in-file move, and a spill/fill context engine (regfile_ctx_fsm).
// Optional macro REGFILE_BYPASS_EN: reads of the register being written
// this cycle return the incoming write data.
module reg_file_ctx
  import reg_file_ctx_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int D = D_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [D-1:0] RaddrA,
  input  logic [D-1:0] RaddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  input  logic         WriteEn,
  input  logic [D-1:0] Waddr,
  input  logic [W-1:0] DataIn,
  input  logic         MoveEn,
  input  logic [D-1:0] MoveSrc,
  input  logic [D-1:0] MoveDst,
  output logic         R0Zero,
  output logic [W-1:0] R1Val,
  input  logic         SpillReq,
  input  logic         FillReq,
  output logic         Busy,
  output logic         CtxDone,
  output logic         SpValid,
  input  logic         SpReady,
  output logic [D-1:0] SpAddr,
  output logic [W-1:0] SpData,
  input  logic         FlValid,
  output logic         FlReady,
  input  logic [W-1:0] FlData
);

  localparam int NREG = nreg(D);

  logic [NREG-1:0][W-1:0] regs;
  logic [D-1:0]           cnt;
  logic                   fill_we;
  logic                   host_we;
  logic                   host_mv;
  logic [W-1:0]           r0_view;

  regfile_ctx_fsm #(.D(D)) u_fsm (
    .clk      (Clk),
    .rst      (Reset),
    .spill_req(SpillReq),
    .fill_req (FillReq),
    .sp_ready (SpReady),
    .fl_valid (FlValid),
    .busy     (Busy),
    .ctx_done (CtxDone),
    .sp_valid (SpValid),
    .fl_ready (FlReady),
    .fill_we  (fill_we),
    .cnt      (cnt)
  );

  // Host write/move are blocked while the engine owns the array.
  assign host_we = WriteEn & ~Busy;
  assign host_mv = MoveEn & ~Busy;

  // Per-register update: fill beat, then host write, then move. The move
  // source is the pre-edge value, so a swap via two moves is safe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (fill_we && cnt == D'(i))
          regs[i] <= FlData;
        else if (host_we && Waddr == D'(i))
          regs[i] <= DataIn;
        else if (host_mv && MoveDst == D'(i))
          regs[i] <= regs[MoveSrc];
      end
    end
  end

  assign SpAddr = cnt;
  assign SpData = regs[cnt];

`ifdef REGFILE_BYPASS_EN
  assign DataOutA = (host_we && RaddrA == Waddr) ? DataIn : regs[RaddrA];
  assign DataOutB = (host_we && RaddrB == Waddr) ? DataIn : regs[RaddrB];
  assign r0_view  = (host_we && Waddr == D'(0)) ? DataIn : regs[0];
  assign R1Val    = (host_we && Waddr == D'(1)) ? DataIn : regs[1];
`else
  assign DataOutA = regs[RaddrA];
  assign DataOutB = regs[RaddrB];
  assign r0_view  = regs[0];
  assign R1Val    = regs[1];
`endif

  assign R0Zero = (r0_view == '0);

endmodule

// File: tb/tb_reg_file_ctx.sv
// Directed bench for reg_file_ctx (W=8, D=4) with a spill beat scoreboard.
module tb_reg_file_ctx;

  logic       Clk, Reset;
  logic [3:0] RaddrA, RaddrB, Waddr, MoveSrc, MoveDst, SpAddr;
  logic [7:0] DataOutA, DataOutB, DataIn, R1Val, SpData, FlData;
  logic       WriteEn, MoveEn, R0Zero, SpillReq, FillReq, Busy, CtxDone;
  logic       SpValid, SpReady, FlValid, FlReady;

  typedef struct {logic [3:0] addr; logic [7:0] data;} beat_t;
  beat_t      q[$];
  beat_t      e;
  logic [7:0] mem [16];
  int         checks = 0;
  int         failures = 0;

  reg_file_ctx #(.W(8), .D(4)) dut (
    .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .DataOutA(DataOutA), .DataOutB(DataOutB), .WriteEn(WriteEn), .Waddr(Waddr),
    .DataIn(DataIn), .MoveEn(MoveEn), .MoveSrc(MoveSrc), .MoveDst(MoveDst),
    .R0Zero(R0Zero), .R1Val(R1Val), .SpillReq(SpillReq), .FillReq(FillReq),
    .Busy(Busy), .CtxDone(CtxDone), .SpValid(SpValid), .SpReady(SpReady),
    .SpAddr(SpAddr), .SpData(SpData), .FlValid(FlValid), .FlReady(FlReady),
    .FlData(FlData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pushes one full spill stream expectation from the bench's register model.
  task automatic push_spill();
    for (int i = 0; i < 16; i++) begin
      e.addr = 4'(i);
      e.data = mem[i];
      q.push_back(e);
    end
  endtask

  initial begin
    int guard;
    int cyc;
    int beat;
    logic rdy;
    logic v;

    Reset = 0; RaddrA = 0; RaddrB = 0; WriteEn = 0; Waddr = 0; DataIn = 0;
    MoveEn = 0; MoveSrc = 0; MoveDst = 0; SpillReq = 0; FillReq = 0;
    SpReady = 0; FlValid = 0; FlData = 0;
    foreach (mem[i]) mem[i] = 8'h00;

    // Reset state
    #2 Reset = 1;
    #2;
    chk("rst_busy", Busy, 0);
    chk("rst_ctxdone", CtxDone, 0);
    chk("rst_spvalid", SpValid, 0);
    chk("rst_flready", FlReady, 0);
    chk("rst_r0zero", R0Zero, 1);
    chk("rst_r1val", R1Val, 0);
    tick();
    Reset = 0;
    tick();

    // Basic writes and dual read
    WriteEn = 1; Waddr = 3; DataIn = 8'h5A; tick();
    Waddr = 7; DataIn = 8'hA5; tick();
    WriteEn = 0; RaddrA = 3; RaddrB = 7; #1;
    chk("rd_a_r3", DataOutA, 8'h5A);
    chk("rd_b_r7", DataOutB, 8'hA5);
    chk("r0zero_after_wr", R0Zero, 1);

    // Write beats move on same destination; then plain move
    WriteEn = 1; Waddr = 2; DataIn = 8'h11; tick();
    Waddr = 4; DataIn = 8'h22; tick();
    Waddr = 4; DataIn = 8'h99; MoveEn = 1; MoveSrc = 2; MoveDst = 4; tick();
    WriteEn = 0; RaddrA = 4; #1;
    chk("wr_beats_move", DataOutA, 8'h99);
    tick();
    MoveEn = 0; #1;
    chk("move_r2_r4", DataOutA, 8'h11);

    // Load R_i = i*3
    WriteEn = 1;
    for (int i = 0; i < 16; i++) begin
      Waddr = 4'(i); DataIn = 8'(i * 3); mem[i] = 8'(i * 3);
      tick();
    end
    WriteEn = 0; #1;
    chk("load_r1val", R1Val, 8'h03);
    chk("load_r0zero", R0Zero, 1);

    // Spill with SpReady toggling 1,0,1,...
    SpillReq = 1; tick(); SpillReq = 0;
    push_spill();
    rdy = 1; guard = 0;
    while (q.size() > 0 && guard < 100) begin
      SpReady = rdy; #4;
      chk("spill_valid", SpValid, 1);
      chk("spill_busy", Busy, 1);
      if (rdy) begin
        e = q.pop_front();
        chk("spill_addr", SpAddr, e.addr);
        chk("spill_data", SpData, e.data);
      end else begin
        chk("spill_addr_held", SpAddr, q[0].addr);
        chk("spill_data_held", SpData, q[0].data);
      end
      tick();
      rdy = ~rdy; guard++;
    end
    chk("spill_no_timeout", guard < 100, 1);
    SpReady = 0; #4;
    chk("spill_done_pulse", CtxDone, 1);
    chk("spill_done_busy", Busy, 0);
    chk("spill_done_valid", SpValid, 0);
    tick(); #4;
    chk("spill_done_once", CtxDone, 0);
    tick();

    // Fill with FlValid gaps; host write to R0 during Busy must be ignored
    FillReq = 1; tick(); FillReq = 0;
    WriteEn = 1; Waddr = 0; DataIn = 8'h77;
    beat = 0; cyc = 0;
    while (beat < 16 && cyc < 100) begin
      v = (cyc % 3) != 2;
      FlValid = v; FlData = 8'(8'hF0 + beat); #4;
      chk("fill_ready", FlReady, 1);
      tick();
      if (v) begin
        mem[beat] = 8'(8'hF0 + beat);
        beat++;
      end
      cyc++;
    end
    chk("fill_no_timeout", cyc < 100, 1);
    FlValid = 0; WriteEn = 0; #4;
    chk("fill_done_pulse", CtxDone, 1);
    tick();
    for (int i = 0; i < 16; i++) begin
      RaddrA = 4'(i); #1;
      chk($sformatf("fill_r%0d", i), DataOutA, mem[i]);
    end
    chk("fill_r0zero", R0Zero, 0);

    // Simultaneous requests: spill wins
    SpillReq = 1; FillReq = 1; tick();
    SpillReq = 0; FillReq = 0; SpReady = 1; #4;
    chk("both_spvalid", SpValid, 1);
    chk("both_flready", FlReady, 0);
    push_spill();
    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      if (guard > 0) #4;
      e = q.pop_front();
      chk("both_addr", SpAddr, e.addr);
      chk("both_data", SpData, e.data);
      tick();
      guard++;
    end
    SpReady = 0; #4;
    chk("both_done", CtxDone, 1);
    tick(); tick();

    // Reset at fill beat 6
    FillReq = 1; tick(); FillReq = 0;
    FlValid = 1;
    for (int k = 0; k < 6; k++) begin
      FlData = 8'(k + 1);
      tick();
    end
    Reset = 1; FlValid = 0; #1;
    chk("rstmid_busy", Busy, 0);
    chk("rstmid_flready", FlReady, 0);
    chk("rstmid_ctxdone", CtxDone, 0);
    chk("rstmid_r0zero", R0Zero, 1);
    chk("rstmid_r1val", R1Val, 0);
    tick();
    Reset = 0; #4;
    chk("rstmid_no_done", CtxDone, 0);
    foreach (mem[i]) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      RaddrB = 4'(i); #1;
      chk($sformatf("rstmid_r%0d", i), DataOutB, mem[i]);
    end
    tick();

    // Same-cycle read of the register being written
    RaddrA = 5; WriteEn = 1; Waddr = 5; DataIn = 8'h3C; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", DataOutA, 8'h3C);
`else
    chk("bypass_same_cycle", DataOutA, 8'h00);
`endif
    tick();
    WriteEn = 0; #1;
    chk("bypass_next_cycle", DataOutA, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
